// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Desc     : Shared types and constants for the i2c command sequencer.
// Revision : 1.0 - initial release
// ============================================================================

package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESOLVE   = 3'd4
  } seq_state_t;

  // Cycles spent in WAIT_BUSY with m_ready still high before the request is
  // considered lost and reissued.
  localparam int c_WB_TIMEOUT = 4;
  localparam int c_WB_CNT_W   = 3;
  localparam int c_FAIL_CNT_W = 8;

  function automatic logic [c_FAIL_CNT_W-1:0] sat_inc(input logic [c_FAIL_CNT_W-1:0] v);
    return (v == {c_FAIL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_fifo
// Desc     : Synchronous FIFO with wrap-bit pointers and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================

module i2c_cmd_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is safe.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_sequencer
// Desc     : Queues write commands and issues them to i2c_master one at a
//            time; transfer retry is built when I2C_SEQ_RETRY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_BYTE   = 4,
  parameter int BYTE_SIZE  = 8,
  parameter int DATA_WIDTH = NUM_BYTE * BYTE_SIZE,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RETRY  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [BYTE_SIZE-2:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    m_req,
  output logic                    m_wen,
  output logic [BYTE_SIZE-2:0]    m_slave_addr,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  input  logic                    m_ready,
  input  logic                    m_addr_err,
  input  logic                    m_noack_err,
  output logic                    seq_busy,
  output logic                    cmd_done,
  output logic                    cmd_fail,
  output logic [c_FAIL_CNT_W-1:0] fail_count
);

  localparam int c_AW = BYTE_SIZE - 1;
  localparam int c_FW = c_AW + DATA_WIDTH;

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic [c_FW-1:0]         w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_can_retry;
  logic                    w_resolve_fail;
  logic [c_WB_CNT_W-1:0]   r_wb_cnt;
  logic                    r_err;
  logic                    r_m_req;
  logic                    r_cmd_done;
  logic                    r_cmd_fail;
  logic [c_AW-1:0]         r_m_addr;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic [c_FAIL_CNT_W-1:0] r_fail_cnt;

  assign w_push = cmd_valid && !w_full;

  i2c_cmd_fifo #(
    .WIDTH (c_FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({cmd_addr, cmd_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef I2C_SEQ_RETRY_EN
  localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [c_RETRY_W-1:0] r_retry_cnt;

  assign w_can_retry = (32'(r_retry_cnt) < MAX_RETRY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retry_cnt <= '0;
    end else if (r_state == S_RESOLVE) begin
      r_retry_cnt <= (r_err && w_can_retry) ? r_retry_cnt + 1'b1 : '0;
    end
  end
`else
  // No retries in this build; MAX_RETRY is non-negative so this is constant 0.
  assign w_can_retry = (MAX_RETRY < 0);
`endif

  assign w_resolve_fail = (r_state == S_RESOLVE) && r_err && !w_can_retry;
  assign w_pop          = (r_state == S_RESOLVE) && !(r_err && w_can_retry);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!w_empty && m_ready) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!m_ready)
          w_state_nxt = S_WAIT_DONE;
        else if (r_wb_cnt == c_WB_CNT_W'(c_WB_TIMEOUT - 1))
          w_state_nxt = S_ISSUE;
      end
      S_WAIT_DONE: if (m_ready) w_state_nxt = S_RESOLVE;
      S_RESOLVE:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m_req    <= 1'b0;
      r_wb_cnt   <= '0;
      r_err      <= 1'b0;
      r_cmd_done <= 1'b0;
      r_cmd_fail <= 1'b0;
      r_fail_cnt <= '0;
      r_m_addr   <= '0;
      r_m_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_m_req    <= (w_state_nxt == S_ISSUE);
      r_cmd_done <= (r_state == S_RESOLVE) && !r_err;
      r_cmd_fail <= w_resolve_fail;
      if (w_state_nxt == S_ISSUE) begin
        r_m_addr <= w_head[c_FW-1 -: c_AW];
        r_m_data <= w_head[DATA_WIDTH-1:0];
      end
      if (r_state == S_ISSUE)
        r_wb_cnt <= '0;
      else if (r_state == S_WAIT_BUSY)
        r_wb_cnt <= r_wb_cnt + 1'b1;
      // An error coinciding with the m_ready rise is still captured here.
      if (r_state == S_ISSUE)
        r_err <= 1'b0;
      else if ((r_state == S_WAIT_DONE) && (m_addr_err || m_noack_err))
        r_err <= 1'b1;
      if (w_resolve_fail)
        r_fail_cnt <= sat_inc(r_fail_cnt);
    end
  end

  assign cmd_ready    = !w_full;
  assign m_req        = r_m_req;
  assign m_wen        = 1'b1;
  assign m_slave_addr = r_m_addr;
  assign m_writedata  = r_m_data;
  assign seq_busy     = !w_empty || (r_state != S_IDLE);
  assign cmd_done     = r_cmd_done;
  assign cmd_fail     = r_cmd_fail;
  assign fail_count   = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cmd_sequencer
// Desc     : Directed bench with a behavioural i2c_master model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_i2c_cmd_sequencer;

  localparam int c_BUSY = 6;
`ifdef I2C_SEQ_RETRY_EN
  localparam int c_ERR_REQS = 3;
`else
  localparam int c_ERR_REQS = 1;
`endif

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    int          mode;
    int          exp_req;
    int          exp_done;
    int          exp_fail;
    int          exp_fcnt;
  } vec_t;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, m_req, m_wen, seq_busy, cmd_done, cmd_fail;
  logic [6:0]  m_slave_addr;
  logic [31:0] m_writedata;
  logic [7:0]  fail_count;
  logic        m_ready = 1'b1;
  logic        m_addr_err = 1'b0;
  logic        m_noack_err = 1'b0;

  int   mdl_mode = 0;
  int   mdl_busy = c_BUSY;
  int   mdl_cnt = 0;
  bit   mdl_hold = 1'b0;
  bit   mdl_ignore = 1'b0;
  bit   mdl_act = 1'b0;
  int   n_req = 0, n_done = 0, n_fail = 0, n_unstable = 0, cyc = 0;
  logic [6:0]  last_a = '0;
  logic [31:0] last_d = '0;
  cap_t cap_q[$];
  int   req_t[$];
  int   n_vec = 0, n_miss = 0;

  i2c_cmd_sequencer #(.MAX_RETRY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .m_req        (m_req),
    .m_wen        (m_wen),
    .m_slave_addr (m_slave_addr),
    .m_writedata  (m_writedata),
    .m_ready      (m_ready),
    .m_addr_err   (m_addr_err),
    .m_noack_err  (m_noack_err),
    .seq_busy     (seq_busy),
    .cmd_done     (cmd_done),
    .cmd_fail     (cmd_fail),
    .fail_count   (fail_count)
  );

  always #5 clk = ~clk;

  // Monitor first, then master model; both on the falling edge.
  // mode 0: ack, 1: data-nack mid transfer, 2: addr-nack as m_ready rises.
  always @(negedge clk) begin
    cyc++;
    if (m_req) begin
      n_req++;
      last_a = m_slave_addr;
      last_d = m_writedata;
      cap_q.push_back({m_slave_addr, m_writedata});
      req_t.push_back(cyc);
    end
    if (cmd_done) n_done++;
    if (cmd_fail) n_fail++;
    if (rst_n && mdl_act && !m_ready && (m_slave_addr !== last_a || m_writedata !== last_d))
      n_unstable++;
    m_addr_err  = 1'b0;
    m_noack_err = 1'b0;
    if (mdl_hold) begin
      m_ready = 1'b0;
      mdl_act = 1'b0;
      mdl_cnt = 0;
    end else if (!m_ready) begin
      if (mdl_cnt <= 1) begin
        m_ready = 1'b1;
        if (mdl_act && mdl_mode == 2) m_addr_err = 1'b1;
        mdl_act = 1'b0;
        mdl_cnt = 0;
      end else begin
        mdl_cnt--;
        if (mdl_act && mdl_mode == 1 && mdl_cnt == 2) m_noack_err = 1'b1;
      end
    end else if (m_req && !mdl_ignore) begin
      m_ready = 1'b0;
      mdl_cnt = mdl_busy;
      mdl_act = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [6:0] a, input logic [31:0] d, output bit acc);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    acc       = cmd_ready;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (!seq_busy) begin
        to = 1'b0;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[5];
    bit   acc, to;
    int   b_req, b_done, b_fail, b_cap, b_t, bad;

    vecs[0] = '{7'h1A, 32'hDEADBEEF, 0, 1, 1, 0, 0};
    vecs[1] = '{7'h55, 32'h01234567, 1, c_ERR_REQS, 0, 1, 1};
    vecs[2] = '{7'h7F, 32'hFFFFFFFF, 0, 1, 1, 0, 1};
    vecs[3] = '{7'h00, 32'h00000000, 2, c_ERR_REQS, 0, 1, 2};
    vecs[4] = '{7'h2B, 32'hA5A55A5A, 0, 1, 1, 0, 2};

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_m_req", m_req, 0);
    check("rst_done_fail", {cmd_done, cmd_fail}, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_m_addr", m_slave_addr, 0);
    check("rst_m_data", m_writedata, 0);
    check("m_wen", m_wen, 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // Single-command vectors against an otherwise idle sequencer
    for (int i = 0; i < 5; i++) begin
      b_req = n_req; b_done = n_done; b_fail = n_fail; b_cap = cap_q.size();
      mdl_mode = vecs[i].mode;
      push(vecs[i].addr, vecs[i].data, acc);
      check($sformatf("v%0d_push_acc", i), acc, 1);
      check($sformatf("v%0d_req_t1", i), m_req, 0);
      tick();
      check($sformatf("v%0d_req_t2", i), m_req, 1);
      wait_idle(300, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_req_cnt", i), n_req - b_req, vecs[i].exp_req);
      check($sformatf("v%0d_done_cnt", i), n_done - b_done, vecs[i].exp_done);
      check($sformatf("v%0d_fail_cnt", i), n_fail - b_fail, vecs[i].exp_fail);
      bad = 0;
      for (int k = b_cap; k < cap_q.size(); k++)
        if (cap_q[k] !== {vecs[i].addr, vecs[i].data}) bad++;
      check($sformatf("v%0d_payload", i), bad, 0);
      check($sformatf("v%0d_fail_count", i), fail_count, vecs[i].exp_fcnt);
      check($sformatf("v%0d_stable", i), n_unstable, 0);
    end
    mdl_mode = 0;

    // Fill the FIFO while the master is busy, then drain in order
    mdl_hold = 1'b1;
    tick();
    tick();
    b_req = n_req; b_done = n_done; b_fail = n_fail; b_cap = cap_q.size();
    for (int i = 0; i < 8; i++) begin
      push(7'(16 + i), 32'hC0DE0000 + 32'(i), acc);
      check($sformatf("fill%0d_acc", i), acc, 1);
    end
    check("fill_ready_low", cmd_ready, 0);
    push(7'h7E, 32'hBAD0BAD0, acc);
    check("fill_9th_ignored", acc, 0);
    mdl_hold = 1'b0;
    wait_idle(600, to);
    check("fill_timeout", to, 0);
    check("fill_req_cnt", n_req - b_req, 8);
    check("fill_done_cnt", n_done - b_done, 8);
    check("fill_fail_cnt", n_fail - b_fail, 0);
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (b_cap + k >= cap_q.size() || cap_q[b_cap + k] !== {7'(16 + k), 32'hC0DE0000 + 32'(k)}) bad++;
    check("fill_order", bad, 0);
    check("fill_stable", n_unstable, 0);

    // Lost request: master ignores m_req, request repeats every 5 cycles
    b_done = n_done; b_t = req_t.size();
    mdl_ignore = 1'b1;
    push(7'h33, 32'h13572468, acc);
    repeat (32) tick();
    check("ign_min_reqs", (req_t.size() - b_t) >= 6, 1);
    bad = 0;
    for (int k = 1; k < 6; k++)
      if (b_t + k >= req_t.size() || req_t[b_t + k] - req_t[b_t + k - 1] != 5) bad++;
    check("ign_req_period", bad, 0);
    check("ign_no_done", n_done - b_done, 0);
    mdl_ignore = 1'b0;
    wait_idle(200, to);
    check("ign_timeout", to, 0);
    check("ign_done", n_done - b_done, 1);

    // Reset while a transfer is in WAIT_DONE with 3 commands queued
    mdl_busy = 20;
    b_req = n_req; b_done = n_done; b_fail = n_fail;
    push(7'h01, 32'h11111111, acc);
    push(7'h02, 32'h22222222, acc);
    push(7'h03, 32'h33333333, acc);
    repeat (4) tick();
    check("rstx_in_transfer", m_ready, 0);
    rst_n = 1'b0;
    tick();
    check("rstx_seq_busy", seq_busy, 0);
    check("rstx_cmd_ready", cmd_ready, 1);
    check("rstx_m_req", m_req, 0);
    check("rstx_fail_count", fail_count, 0);
    check("rstx_m_addr", m_slave_addr, 0);
    rst_n = 1'b1;
    repeat (30) tick();
    check("rstx_req_cnt", n_req - b_req, 1);
    check("rstx_no_done", n_done - b_done, 0);
    check("rstx_no_fail", n_fail - b_fail, 0);
    check("rstx_idle", {seq_busy, cmd_ready}, 2'b01);
    mdl_busy = c_BUSY;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Upstream command stage for i2c_master. Buffers write commands (7-bit slave address plus NUM_BYTE data bytes) in a small FIFO and issues them one at a time on the master's req/ready handshake. Latches the master's address/no-ack error pulses per transfer and reports per-command done/fail. Optionally retries failed transfers. Typical use: streaming codec/sensor register-init sequences from a CPU or init ROM into i2c_master.

Parameters:
NUM_BYTE, 4, data bytes per command; must equal i2c_master NUM_BYTE
BYTE_SIZE, 8, bits per byte; slave address is BYTE_SIZE-1 bits
DATA_WIDTH, NUM_BYTE*BYTE_SIZE, command payload width
FIFO_DEPTH, 8, command FIFO entries; power of 2, >=2
MAX_RETRY, 2, reissues after a failed transfer (used only with I2C_SEQ_RETRY_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command push request
cmd_ready  out  1  FIFO not full; push happens when cmd_valid & cmd_ready
cmd_addr  in  BYTE_SIZE-1  slave address
cmd_data  in  DATA_WIDTH  payload, byte0 in MSBs
m_req  out  1  one-cycle request pulse to master
m_wen  out  1  constant 1 (write only)
m_slave_addr  out  BYTE_SIZE-1  head-command address, held through transfer
m_writedata  out  DATA_WIDTH  head-command data, held through transfer
m_ready  in  1  master idle
m_addr_err  in  1  master address-nack pulse
m_noack_err  in  1  master data-nack pulse
seq_busy  out  1  FIFO non-empty or FSM not IDLE
cmd_done  out  1  one-cycle pulse: command completed without error
cmd_fail  out  1  one-cycle pulse: command dropped after error
fail_count  out  8  saturating count of cmd_fail pulses

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO emptied; FSM to IDLE; m_req=0, cmd_done=0, cmd_fail=0, fail_count=0, err latch=0, retry count=0, m_slave_addr=0, m_writedata=0; cmd_ready=1 from the first cycle after reset. Reset mid-transfer abandons the command without a done or fail pulse. i2c_master is reset separately.
- FIFO: registered write and read pointers with an extra wrap bit. Full when the pointers differ only in the wrap bit; empty when they are equal. Push when full is ignored (cmd_ready=0). Push and pop in the same cycle are both legal, including when the FIFO is full.
- m_slave_addr and m_writedata are taken from the FIFO head and driven from registers. Head is popped only at command completion.
- FSM states and transitions:
  - IDLE: if FIFO not empty and m_ready=1, go to ISSUE.
  - ISSUE: m_req=1 for exactly this cycle; clear err latch; go to WAIT_BUSY.
  - WAIT_BUSY: on m_ready=0, go to WAIT_DONE. If m_ready is still 1 after 4 cycles, go back to ISSUE (lost request).
  - WAIT_DONE: on m_addr_err or m_noack_err, set err latch. On m_ready=1, go to RESOLVE.
  - RESOLVE (1 cycle): if err=0, pop and pulse cmd_done. If err=1, apply the retry policy (Optional Feature). Then go to IDLE.
- An error pulse arriving in the same cycle that m_ready rises is still latched.
- Latency: FIFO empty, push at cycle t, master idle -> m_req asserted at t+2.
- Back-to-back commands: next m_req no earlier than 2 cycles after RESOLVE.
- fail_count saturates at 255.

Optional Feature:
I2C_SEQ_RETRY_EN
- Defined:
  - RESOLVE with err=1 and retry count < MAX_RETRY: increment retry count, do not pop, go to IDLE. The same command is reissued.
  - RESOLVE with err=1 and retry count = MAX_RETRY: pop, pulse cmd_fail, clear retry count.
  - Retry count is also cleared on cmd_done.
- Undefined: RESOLVE with err=1 always pops and pulses cmd_fail; no retry counter is built.

Decomposition:
- Shared package i2c_pkg: FSM state encoding (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESOLVE), WAIT_BUSY timeout constant 4, fail_count width 8.
- One sub-module, i2c_cmd_fifo: parameterised synchronous FIFO with width BYTE_SIZE-1+DATA_WIDTH, depth FIFO_DEPTH, and full/empty outputs. Reusable by a future read-path stage.

Test Plan:
- Push one command (addr 0x1A, data 0xDEADBEEF) with a master model that acks everything -> single m_req, m_slave_addr=0x1A and m_writedata=0xDEADBEEF stable until m_ready rises, then one cmd_done; seq_busy falls.
- Push 8 commands back-to-back with the master held busy -> cmd_ready=0 after the 8th push; a 9th push is ignored; all 8 commands are issued in order with 8 cmd_done pulses.
- Model asserts m_noack_err on the first command, retry enabled, MAX_RETRY=2 -> 3 m_req pulses for the same data, then cmd_fail and fail_count=1. With the macro undefined -> 1 m_req, cmd_fail, and the FIFO advances to the next command.
- m_addr_err asserted in the same cycle m_ready rises -> cmd_fail (or a retry), not cmd_done.
- rst_n=0 during WAIT_DONE with 3 commands queued -> FIFO empty, no pulses, cmd_ready=1 and seq_busy=0 after reset.
- Model ignores m_req, leaving m_ready=1 -> m_req is reissued every 5 cycles.
